// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single RF write port between WB and the multiplier, parking collisions
// in an in-order queue. Define RF_WB_ARB_FWD_EN to forward the youngest queued data to decode.
module rf_wb_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int DEPTH        = 4,
   parameter int STALL_THRESH = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wb_valid,
   input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
   input  logic [DATA_WIDTH-1:0]   i_wb_data,
   input  logic                    i_mul_valid,
   input  logic [ADDR_WIDTH-1:0]   i_mul_addr,
   input  logic [DATA_WIDTH-1:0]   i_mul_data,
   input  logic [ADDR_WIDTH-1:0]   i_rs,
   input  logic [ADDR_WIDTH-1:0]   i_rt,
   output logic                    o_rf_we,
   output logic [ADDR_WIDTH-1:0]   o_rf_addr,
   output logic [DATA_WIDTH-1:0]   o_rf_wd,
   output logic                    o_rs_pend,
   output logic                    o_rt_pend,
   output logic                    o_stall,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_overflow
`ifdef RF_WB_ARB_FWD_EN
   ,
   output logic [DATA_WIDTH-1:0]   o_rs_fwd_data,
   output logic [DATA_WIDTH-1:0]   o_rt_fwd_data,
   output logic                    o_rs_fwd_vld,
   output logic                    o_rt_fwd_vld
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg, wb_slot;
   logic [CNT_W-1:0]      count_reg, count_next, free_slots;
   logic                  overflow_reg;

   logic mul_req, wb_req, q_empty, pop;
   logic push_mul_req, push_wb_req, push_mul, push_wb, drop;
   logic [DEPTH-1:0] slot_valid, rs_hit, rt_hit;

   // Register 0 is hardwired, so such requests simply vanish.
   assign mul_req = i_mul_valid && (i_mul_addr != '0);
   assign wb_req  = i_wb_valid && (i_wb_addr != '0);
   assign q_empty = (count_reg == '0);
   assign pop     = !q_empty;

   always_comb begin
      o_rf_we      = 1'b0;
      o_rf_addr    = '0;
      o_rf_wd      = '0;
      push_mul_req = 1'b0;
      push_wb_req  = 1'b0;
      if (!i_rst_n) begin
         o_rf_we = 1'b0;
      end else if (q_empty) begin
         if (mul_req) begin
            o_rf_we     = 1'b1;
            o_rf_addr   = i_mul_addr;
            o_rf_wd     = i_mul_data;
            push_wb_req = wb_req;
         end else if (wb_req) begin
            o_rf_we   = 1'b1;
            o_rf_addr = i_wb_addr;
            o_rf_wd   = i_wb_data;
         end
      end else begin
         o_rf_we      = 1'b1;
         o_rf_addr    = addr_mem[rd_ptr_reg];
         o_rf_wd      = data_mem[rd_ptr_reg];
         push_mul_req = mul_req;
         push_wb_req  = wb_req;
      end
   end

   // The head leaving this cycle frees its slot for the incoming pushes.
   assign free_slots = CNT_W'(DEPTH) - count_reg + CNT_W'(pop);
   assign push_mul   = push_mul_req && (free_slots != '0);
   assign push_wb    = push_wb_req && (free_slots > (push_mul ? CNT_W'(1) : CNT_W'(0)));
   assign drop       = (push_mul_req && !push_mul) || (push_wb_req && !push_wb);
   assign wb_slot    = wr_ptr_reg + PTR_W'(push_mul);
   assign count_next = count_reg - CNT_W'(pop) + CNT_W'(push_mul) + CNT_W'(push_wb);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
         wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_mul) + PTR_W'(push_wb);
         count_reg  <= count_next;
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_mul) begin
         addr_mem[wr_ptr_reg] <= i_mul_addr;
         data_mem[wr_ptr_reg] <= i_mul_data;
      end
      if (push_wb) begin
         addr_mem[wb_slot] <= i_wb_addr;
         data_mem[wb_slot] <= i_wb_data;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [PTR_W-1:0] age;
         assign age            = PTR_W'(gi) - rd_ptr_reg;
         assign slot_valid[gi] = ({1'b0, age} < count_reg);
         assign rs_hit[gi]     = slot_valid[gi] && (addr_mem[gi] == i_rs) && (i_rs != '0);
         assign rt_hit[gi]     = slot_valid[gi] && (addr_mem[gi] == i_rt) && (i_rt != '0);
      end
   endgenerate

`ifdef RF_WB_ARB_FWD_EN
   logic [PTR_W-1:0] fwd_idx;

   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      o_rs_fwd_data = '0;
      o_rt_fwd_data = '0;
      fwd_idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr_reg + PTR_W'(k);
         if (rs_hit[fwd_idx])
            o_rs_fwd_data = data_mem[fwd_idx];
         if (rt_hit[fwd_idx])
            o_rt_fwd_data = data_mem[fwd_idx];
      end
   end

   assign o_rs_fwd_vld = |rs_hit;
   assign o_rt_fwd_vld = |rt_hit;
   assign o_rs_pend    = 1'b0;
   assign o_rt_pend    = 1'b0;
`else
   assign o_rs_pend = |rs_hit;
   assign o_rt_pend = |rt_hit;
`endif

   assign o_stall    = (count_reg >= CNT_W'(STALL_THRESH));
   assign o_count    = count_reg;
   assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-level reference model checked every negedge,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_rf_wb_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_valid = 1'b0, mul_valid = 1'b0;
   logic [AW-1:0] wb_addr = '0, mul_addr = '0, rs = '0, rt = '0;
   logic [DW-1:0] wb_data = '0, mul_data = '0;
   logic          rf_we, rs_pend, rt_pend, stall, overflow;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wd;
   logic [CW-1:0] count;
`ifdef RF_WB_ARB_FWD_EN
   logic [DW-1:0] rs_fwd_data, rt_fwd_data;
   logic          rs_fwd_vld, rt_fwd_vld;
`endif

   rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STALL_THRESH(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_mul_valid(mul_valid), .i_mul_addr(mul_addr), .i_mul_data(mul_data),
      .i_rs(rs), .i_rt(rt),
      .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_wd(rf_wd),
      .o_rs_pend(rs_pend), .o_rt_pend(rt_pend), .o_stall(stall),
      .o_count(count), .o_overflow(overflow)
`ifdef RF_WB_ARB_FWD_EN
      , .o_rs_fwd_data(rs_fwd_data), .o_rt_fwd_data(rt_fwd_data),
      .o_rs_fwd_vld(rs_fwd_vld), .o_rt_fwd_vld(rt_fwd_vld)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q[$];
   bit            m_ovf = 1'b0;
   logic [DW-1:0] model_rf [32];
   logic [DW-1:0] dut_rf [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queue; pop before pushes, pushes MUL then WB.
   always @(negedge clk) begin
      bit            mv, wv, e_we, e_rsp, e_rtp;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d, e_rsd, e_rtd;
      ent_t          h, n;
      e_we = 0; e_a = '0; e_d = '0;
      e_rsp = 0; e_rtp = 0; e_rsd = '0; e_rtd = '0;
      if (!rst_n) begin
         q.delete();
         m_ovf = 0;
      end
      foreach (q[i]) begin
         if (rs != 0 && q[i].a == rs) begin e_rsp = 1; e_rsd = q[i].d; end
         if (rt != 0 && q[i].a == rt) begin e_rtp = 1; e_rtd = q[i].d; end
      end
      chk("count", count, q.size());
      chk("stall", stall, q.size() >= 2);
      chk("overflow", overflow, m_ovf);
`ifdef RF_WB_ARB_FWD_EN
      chk("rs_pend", rs_pend, 0);
      chk("rt_pend", rt_pend, 0);
      chk("rs_fwd_vld", rs_fwd_vld, e_rsp);
      chk("rt_fwd_vld", rt_fwd_vld, e_rtp);
      if (e_rsp) chk("rs_fwd_data", rs_fwd_data, e_rsd);
      if (e_rtp) chk("rt_fwd_data", rt_fwd_data, e_rtd);
      if (!rst_n) begin
         chk("rs_fwd_data_rst", rs_fwd_data, 0);
         chk("rt_fwd_data_rst", rt_fwd_data, 0);
      end
`else
      chk("rs_pend", rs_pend, e_rsp);
      chk("rt_pend", rt_pend, e_rtp);
`endif
      if (rst_n) begin
         mv = mul_valid && (mul_addr != 0);
         wv = wb_valid && (wb_addr != 0);
         if (q.size() == 0) begin
            if (mv) begin
               e_we = 1; e_a = mul_addr; e_d = mul_data;
               if (wv) begin n.a = wb_addr; n.d = wb_data; q.push_back(n); end
            end else if (wv) begin
               e_we = 1; e_a = wb_addr; e_d = wb_data;
            end
         end else begin
            h = q.pop_front();
            e_we = 1; e_a = h.a; e_d = h.d;
            if (mv) begin
               if (q.size() < DEPTH) begin n.a = mul_addr; n.d = mul_data; q.push_back(n); end
               else m_ovf = 1;
            end
            if (wv) begin
               if (q.size() < DEPTH) begin n.a = wb_addr; n.d = wb_data; q.push_back(n); end
               else m_ovf = 1;
            end
         end
      end
      chk("rf_we", rf_we, e_we);
      if (e_we || !rst_n) begin
         chk("rf_addr", rf_addr, e_a);
         chk("rf_wd", rf_wd, e_d);
      end
      if (e_we) model_rf[e_a] = e_d;
      if (rf_we) dut_rf[rf_addr] = rf_wd;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit mv, input int ma, input int md, input bit wv, input int wa, input int wd);
      mul_valid = mv; mul_addr = AW'(ma); mul_data = DW'(md);
      wb_valid  = wv; wb_addr  = AW'(wa); wb_data  = DW'(wd);
   endtask

   initial begin
      foreach (model_rf[i]) begin model_rf[i] = '0; dut_rf[i] = '0; end
      repeat (2) tick();
      #3;
      chk("reset_count", count, 0);
      chk("reset_we", rf_we, 0);
      rst_n = 1'b1;
      tick();

      // WB only goes straight through
      drive(0, 0, 0, 1, 3, 'h11);
      #3;
      chk("wb_only_we", rf_we, 1);
      chk("wb_only_addr", rf_addr, 3);
      chk("wb_only_wd", rf_wd, 'h11);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("wb_only_count", count, 0);
      tick();

      // Collision: MUL first, WB next cycle
      drive(1, 6, 'hB, 1, 5, 'hA);
      #3;
      chk("coll_c0_addr", rf_addr, 6);
      chk("coll_c0_wd", rf_wd, 'hB);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("coll_c1_count", count, 1);
      chk("coll_c1_addr", rf_addr, 5);
      chk("coll_c1_wd", rf_wd, 'hA);
      tick();
      #3;
      chk("coll_c2_count", count, 0);
      tick();

      // Fill to full and overflow
      drive(1, 1, 'h21, 1, 2, 'h22); tick();
      drive(1, 3, 'h23, 1, 4, 'h24); tick();
      drive(1, 13, 'h33, 1, 14, 'h34); tick();
      drive(1, 15, 'h35, 1, 16, 'h36); tick();
      drive(1, 17, 'h37, 1, 18, 'h38); tick();
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("full_count", count, 4);
      chk("full_stall", stall, 1);
      chk("full_overflow", overflow, 1);
      chk("full_head_addr", rf_addr, 14);
      repeat (5) tick();
      #3;
      chk("drained_count", count, 0);
      chk("overflow_sticky", overflow, 1);
      tick();

      // Two queued writes to r7
      drive(1, 9, 'h3, 1, 12, 'h6); tick();
      drive(1, 7, 'h1, 1, 7, 'h2); tick();
      drive(0, 0, 0, 0, 0, 0);
      rs = 7; rt = 12;
      #3;
`ifdef RF_WB_ARB_FWD_EN
      chk("r7_fwd_vld", rs_fwd_vld, 1);
      chk("r7_fwd_data", rs_fwd_data, 'h2);
`else
      chk("r7_rs_pend", rs_pend, 1);
`endif
      chk("r12_rt_pend", rt_pend, 0);
      repeat (3) tick();
      rs = 0; rt = 0;
      chk("r7_final_dut", dut_rf[7], 'h2);
      chk("r7_final_model", model_rf[7], 'h2);

      // addr 0 request discarded
      drive(1, 9, 'h5, 1, 0, 'h77);
      #3;
      chk("zero_addr", rf_addr, 9);
      chk("zero_wd", rf_wd, 'h5);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("zero_count", count, 0);
      tick();

      // Async reset with three queued entries
      drive(1, 1, 1, 1, 2, 2); tick();
      drive(1, 3, 3, 1, 4, 4); tick();
      drive(1, 5, 5, 1, 6, 6); tick();
      drive(1, 9, 9, 0, 0, 0);
      #1;
      chk("pre_reset_count", count, 3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_we", rf_we, 0);
      chk("async_rst_overflow", overflow, 0);
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
               $urandom_range(0, 9) < 5, $urandom_range(0, 7), $urandom);
         rs = AW'($urandom_range(0, 7));
         rt = AW'($urandom_range(0, 7));
         rst_n = ($urandom_range(0, 249) != 0);
         tick();
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (6) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
